comp_track_nb: RTL and testbench
================================

Name: comp_track_nb

Overview:
- Registered, streaming n-bit comparator with a valid handshake and selectable signed/unsigned compare.
- Each accepted sample is compared against a reference value; registered eq/lt/gt flags are produced.
- Running minimum, maximum and sample count are tracked until cleared.
- Sits between sample sources (switch/ADC/counter datapaths) and display/decision logic that needs stable, clocked compare results plus statistics.

Parameters:
- N, 8, data and reference width in bits (N >= 2).
- CNT_W, 16, width of sample counter (and streak counter when enabled).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear of tracker state (min/max/count/FSM); compare flags unaffected.
- in_valid  input  1  in_data is a sample this cycle; always accepted (no backpressure).
- in_data  input  N  sample value.
- ref_val  input  N  reference value compared against in_data; sampled with in_valid.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with in_valid.
- out_valid  output  1  one-cycle pulse, registered compare flags updated.
- eq  output  1  registered in_data == ref_val.
- lt  output  1  registered in_data < ref_val.
- gt  output  1  registered in_data > ref_val.
- stat_valid  output  1  high when min_val/max_val hold at least one sample.
- min_val  output  N  smallest sample since last clear/reset.
- max_val  output  N  largest sample since last clear/reset.
- sample_cnt  output  CNT_W  samples accepted since last clear/reset; saturating.

Behaviour:
- Reset (async, immediate):
  - out_valid, eq, lt, gt, stat_valid = 0.
  - min_val, max_val, sample_cnt = 0.
  - FSM = EMPTY.
- Compare path:
  - On a cycle with in_valid=1, the next edge registers flags and sets out_valid=1. Latency is exactly 1 cycle.
  - Exactly one of eq/lt/gt is 1 after the first valid sample.
  - Flags hold their value between samples; out_valid is 0 on cycles with no sample.
  - signed_mode=1 interprets both operands as two's complement.
- Tracker FSM, states EMPTY, TRACK, SAT:
  - EMPTY: stat_valid=0. A sample loads min_val=max_val=in_data and sample_cnt=1, then goes to TRACK.
  - TRACK: a sample increments sample_cnt. min_val is replaced if in_data < min_val; max_val is replaced if in_data > max_val. Both use the sample's signed_mode. When sample_cnt reaches all-ones, go to SAT.
  - SAT: sample_cnt holds at 2^CNT_W-1. min/max keep updating.
  - TRACK and SAT: stat_valid=1.
- clr:
  - Any state goes to EMPTY next edge; min/max/count zeroed.
  - If clr and in_valid are both 1, clr wins for the tracker (sample not counted), but the compare path still produces flags and out_valid for that sample.
- Signed-mode change mid-stream: stored min/max are not reinterpreted. The new mode is used for subsequent comparisons only; the user issues clr on mode change if consistent statistics are needed.
- Edge cases:
  - Equal sample to current min/max: no change.
  - CNT_W=1: EMPTY to TRACK at count 1 = all-ones, so go directly to SAT.
- Reset mid-stream: all state is lost immediately; the first post-reset sample behaves as in EMPTY.

Optional Feature:
- Macro COMP_STREAK_EN.
- Defined:
  - Adds output port gt_streak (CNT_W), reset 0.
  - Each sample with in_data > ref_val increments it (saturating). Each sample that is not gt sets it to 0.
  - clr also zeroes it. It updates on the same edge as gt.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then in_valid=1, in_data=8'h10, ref_val=8'h10, signed_mode=0 -> next cycle out_valid=1, eq=1, lt=0, gt=0; min_val=max_val=8'h10, sample_cnt=1, stat_valid=1.
- Signed compare: in_data=8'hF0, ref_val=8'h05, signed_mode=1 -> lt=1. Same data with signed_mode=0 -> gt=1.
- Sequence 8'h30, 8'h05, 8'h7F, 8'h40 (unsigned, consecutive cycles) -> after last, min_val=8'h05, max_val=8'h7F, sample_cnt=4; out_valid pulses 4 consecutive cycles, then 0.
- clr asserted with in_valid=1, in_data=8'h99, ref_val=8'h00 -> gt=1, out_valid=1; stat_valid=0, sample_cnt=0, min/max=0.
- CNT_W=3: feed 9 samples -> sample_cnt saturates at 7 (FSM SAT) while max_val still updates on the 9th sample if larger.
- Assert reset asynchronously mid-stream between clock edges -> all outputs 0 immediately. With COMP_STREAK_EN, 3 gt samples then 1 eq -> gt_streak 1,2,3,0.

Source files
------------

// File: rtl/comp_track_nb.sv
// Streaming comparator with registered eq/lt/gt flags and running min/max/count tracker.
// Optional COMP_STREAK_EN adds a saturating count of consecutive greater-than samples.
module comp_track_nb #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  input  logic [N-1:0]     ref_val,
  input  logic             signed_mode,
  output logic             out_valid,
  output logic             eq,
  output logic             lt,
  output logic             gt,
  output logic             stat_valid,
  output logic [N-1:0]     min_val,
  output logic [N-1:0]     max_val,
`ifdef COMP_STREAK_EN
  output logic [CNT_W-1:0] gt_streak,
`endif
  output logic [CNT_W-1:0] sample_cnt
);

  typedef enum logic [1:0] {EMPTY, TRACK, SAT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state, state_nxt;

  // Flipping the sign bit maps two's complement order onto unsigned order.
  function automatic logic less(input logic [N-1:0] a, input logic [N-1:0] b, input logic sm);
    logic [N-1:0] ab;
    logic [N-1:0] bb;
    ab = a;
    bb = b;
    if (sm) begin
      ab[N-1] = ~a[N-1];
      bb[N-1] = ~b[N-1];
    end
    return ab < bb;
  endfunction

  logic smp_lt_ref, smp_gt_ref, smp_lt_min, smp_gt_max;
  assign smp_lt_ref = less(in_data, ref_val, signed_mode);
  assign smp_gt_ref = less(ref_val, in_data, signed_mode);
  assign smp_lt_min = less(in_data, min_val, signed_mode);
  assign smp_gt_max = less(max_val, in_data, signed_mode);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      gt        <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        eq <= (in_data == ref_val);
        lt <= smp_lt_ref;
        gt <= smp_gt_ref;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = EMPTY;
    end else if (in_valid) begin
      case (state)
        EMPTY:   state_nxt = (CNT_ONE == CNT_MAX) ? SAT : TRACK;
        TRACK:   if (sample_cnt == CNT_MAX - CNT_ONE) state_nxt = SAT;
        SAT:     state_nxt = SAT;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    stat_valid = (state != EMPTY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_val    <= '0;
      max_val    <= '0;
      sample_cnt <= '0;
    end else if (clr) begin
      min_val    <= '0;
      max_val    <= '0;
      sample_cnt <= '0;
    end else if (in_valid) begin
      if (state == EMPTY) begin
        min_val    <= in_data;
        max_val    <= in_data;
        sample_cnt <= CNT_ONE;
      end else begin
        if (smp_lt_min) min_val <= in_data;
        if (smp_gt_max) max_val <= in_data;
        if (state == TRACK) sample_cnt <= sample_cnt + CNT_ONE;
      end
    end
  end

`ifdef COMP_STREAK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gt_streak <= '0;
    end else if (clr) begin
      gt_streak <= '0;
    end else if (in_valid) begin
      if (!smp_gt_ref)              gt_streak <= '0;
      else if (gt_streak != CNT_MAX) gt_streak <= gt_streak + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_comp_track_nb.sv
// Directed bench for comp_track_nb: default instance plus a CNT_W=3 instance for saturation.
module tb_comp_track_nb;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [7:0] ref_val = '0;
  logic       signed_mode = 1'b0;

  logic        out_valid, eq, lt, gt, stat_valid;
  logic [7:0]  min_val, max_val;
  logic [15:0] sample_cnt;
  logic        out_valid3, eq3, lt3, gt3, stat_valid3;
  logic [7:0]  min_val3, max_val3;
  logic [2:0]  sample_cnt3;
`ifdef COMP_STREAK_EN
  logic [15:0] gt_streak;
  logic [2:0]  gt_streak3;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  comp_track_nb #(.N(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .ref_val(ref_val), .signed_mode(signed_mode), .out_valid(out_valid), .eq(eq),
    .lt(lt), .gt(gt), .stat_valid(stat_valid), .min_val(min_val), .max_val(max_val),
`ifdef COMP_STREAK_EN
    .gt_streak(gt_streak),
`endif
    .sample_cnt(sample_cnt)
  );

  comp_track_nb #(.N(8), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .ref_val(ref_val), .signed_mode(signed_mode), .out_valid(out_valid3), .eq(eq3),
    .lt(lt3), .gt(gt3), .stat_valid(stat_valid3), .min_val(min_val3), .max_val(max_val3),
`ifdef COMP_STREAK_EN
    .gt_streak(gt_streak3),
`endif
    .sample_cnt(sample_cnt3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one sample, clock it in, and leave time at edge+1 for checking.
  task automatic sample(input logic [7:0] d, input logic [7:0] r, input logic sm, input logic c);
    in_valid    = 1'b1;
    in_data     = d;
    ref_val     = r;
    signed_mode = sm;
    clr         = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic idle(input logic c);
    in_valid = 1'b0;
    clr      = c;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flags", {eq, lt, gt}, 3'b000);
    chk("rst_stat_valid", stat_valid, 0);
    chk("rst_minmax", {min_val, max_val}, 16'h0000);
    chk("rst_cnt", sample_cnt, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    sample(8'h10, 8'h10, 1'b0, 1'b0);
    chk("first_out_valid", out_valid, 1);
    chk("first_flags", {eq, lt, gt}, 3'b100);
    chk("first_min", min_val, 8'h10);
    chk("first_max", max_val, 8'h10);
    chk("first_cnt", sample_cnt, 1);
    chk("first_stat_valid", stat_valid, 1);

    idle(1'b0);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_flags_hold", {eq, lt, gt}, 3'b100);

    sample(8'hF0, 8'h05, 1'b1, 1'b0);
    chk("signed_flags", {eq, lt, gt}, 3'b010);
    chk("signed_min", min_val, 8'hF0);
    chk("signed_max", max_val, 8'h10);
    sample(8'hF0, 8'h05, 1'b0, 1'b0);
    chk("unsigned_flags", {eq, lt, gt}, 3'b001);
    chk("unsigned_max", max_val, 8'hF0);
    chk("cnt_three", sample_cnt, 3);

    idle(1'b1);
    chk("clr_stat_valid", stat_valid, 0);
    chk("clr_cnt", sample_cnt, 0);
    chk("clr_minmax", {min_val, max_val}, 16'h0000);
    chk("clr_flags_hold", {eq, lt, gt}, 3'b001);
    chk("clr_out_valid", out_valid, 0);

    sample(8'h30, 8'h40, 1'b0, 1'b0);
    chk("seq0_out_valid", out_valid, 1);
    sample(8'h05, 8'h40, 1'b0, 1'b0);
    chk("seq1_out_valid", out_valid, 1);
    chk("seq1_min", min_val, 8'h05);
    chk("seq1_max", max_val, 8'h30);
    sample(8'h7F, 8'h40, 1'b0, 1'b0);
    chk("seq2_out_valid", out_valid, 1);
    chk("seq2_flags", {eq, lt, gt}, 3'b001);
    sample(8'h40, 8'h40, 1'b0, 1'b0);
    chk("seq3_out_valid", out_valid, 1);
    chk("seq3_flags", {eq, lt, gt}, 3'b100);
    chk("seq_min", min_val, 8'h05);
    chk("seq_max", max_val, 8'h7F);
    chk("seq_cnt", sample_cnt, 4);
    sample(8'h05, 8'h40, 1'b0, 1'b0);
    chk("equal_min_kept", min_val, 8'h05);
    chk("equal_cnt", sample_cnt, 5);
    idle(1'b0);
    chk("seq_end_out_valid", out_valid, 0);

    sample(8'h99, 8'h00, 1'b0, 1'b1);
    chk("clrsmp_out_valid", out_valid, 1);
    chk("clrsmp_flags", {eq, lt, gt}, 3'b001);
    chk("clrsmp_stat_valid", stat_valid, 0);
    chk("clrsmp_cnt", sample_cnt, 0);
    chk("clrsmp_minmax", {min_val, max_val}, 16'h0000);
    chk("clrsmp_cnt3", sample_cnt3, 0);

    for (int i = 1; i <= 7; i++) sample(8'(i), 8'h00, 1'b0, 1'b0);
    chk("sat7_cnt3", sample_cnt3, 7);
    chk("sat7_stat3", stat_valid3, 1);
    sample(8'h08, 8'h00, 1'b0, 1'b0);
    chk("sat8_cnt3", sample_cnt3, 7);
    chk("sat8_max3", max_val3, 8'h08);
    sample(8'h50, 8'h00, 1'b0, 1'b0);
    chk("sat9_cnt3", sample_cnt3, 7);
    chk("sat9_max3", max_val3, 8'h50);
    chk("sat9_min3", min_val3, 8'h01);
    chk("sat9_cnt", sample_cnt, 9);

    in_valid = 1'b1;
    in_data  = 8'h20;
    ref_val  = 8'h10;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pre_rst_gt", gt, 1);
    reset = 1'b1;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_flags", {eq, lt, gt}, 3'b000);
    chk("async_stat_valid", stat_valid, 0);
    chk("async_minmax", {min_val, max_val}, 16'h0000);
    chk("async_cnt", sample_cnt, 0);
    chk("async_cnt3", sample_cnt3, 0);
    #1;
    reset = 1'b0;
    sample(8'h33, 8'h44, 1'b0, 1'b0);
    chk("post_rst_cnt", sample_cnt, 1);
    chk("post_rst_minmax", {min_val, max_val}, 16'h3333);
    chk("post_rst_flags", {eq, lt, gt}, 3'b010);

`ifdef COMP_STREAK_EN
    idle(1'b1);
    chk("streak_clr", gt_streak, 0);
    sample(8'h09, 8'h01, 1'b0, 1'b0);
    chk("streak_1", gt_streak, 1);
    sample(8'h09, 8'h01, 1'b0, 1'b0);
    chk("streak_2", gt_streak, 2);
    sample(8'h09, 8'h01, 1'b0, 1'b0);
    chk("streak_3", gt_streak, 3);
    sample(8'h01, 8'h01, 1'b0, 1'b0);
    chk("streak_0", gt_streak, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
